// File: rtl/rca_pkg.sv
// Shared types and helpers for the word-serial ripple-carry adder sequencer.
// The index-width helper keeps the word counter sized to the word count.
package rca_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;

  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_ctrl_rca.sv
// Single WIDTH-bit ripple-carry adder slice, reused once per word by the sequencer.
module rca #(
  parameter int WIDTH = 8
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/rca_seq_ctrl.sv
// Word-serial wide adder: one WIDTH-bit slice is reused for WORDS cycles,
// least significant word first, with the carry held in a register between words.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   cin,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   cout,
  output logic                   busy
);

  localparam int TW = WIDTH * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  rca_seq_state_t state, state_next;

  logic [TW-1:0]    opa;
  logic [TW-1:0]    opb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] slice_s;
  logic             slice_cout;
  logic             last_word;

  assign last_word = (idx == LAST_IDX);

  rca #(.WIDTH(WIDTH)) u_rca (
    .cin  (carry),
    .a    (opa[WIDTH-1:0]),
    .b    (opb[WIDTH-1:0]),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  // The index holds at the last word instead of wrapping, so it never aliases word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) s[w*WIDTH +: WIDTH] <= slice_s;
          end
          carry <= slice_cout;
          opa   <= opa >> WIDTH;
          opb   <= opb >> WIDTH;
          if (last_word) begin
            cout <= slice_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed vector table, multi-cycle
// handshake/reset corner cases, and randomized traffic against an arithmetic model.
module tb_rca_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int TW    = WIDTH * WORDS;
  localparam int NRAND = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          cin;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] s;
  logic          cout;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW-1:0] s;
    logic          cout;
  } vec_t;

  vec_t vecs[6];

  rca_seq_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one operation from IDLE (called at a negedge) and waits for the result.
  task automatic applyStimulus(input logic [TW-1:0] va, input logic [TW-1:0] vb, input logic vc,
                               output logic [TW-1:0] rs, output logic rc,
                               output int lat, output int busy_cnt);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rs = s;
    rc = cout;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] rs;
    logic          rc;
    int            lat;
    int            bcnt;
    int            seen;
    logic [TW:0]   expq[$];
    int            got;
    int            last_acc;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cin       = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset s", 64'(s), 64'd0);
    checkOutput("reset cout", 64'(cout), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++) begin
      checkOutput("vec in_ready before", 64'(in_ready), 64'd1);
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bcnt);
      checkOutput("vec latency", 64'(lat), 64'(WORDS));
      checkOutput("vec busy cycles", 64'(bcnt), 64'(WORDS));
      checkOutput("vec s", 64'(rs), 64'(vecs[i].s));
      checkOutput("vec cout", 64'(rc), 64'(vecs[i].cout));
      releaseResult();
      checkOutput("vec idle after release", 64'(in_ready), 64'd1);
    end

    $display("[TB] consumer stall in DONE");
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1, rs, rc, lat, bcnt);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall s", 64'(s), 64'h2345_678A);
      checkOutput("stall cout", 64'(cout), 64'd0);
      checkOutput("stall in_ready", 64'(in_ready), 64'd0);
    end
    releaseResult();
    checkOutput("stall idle after release", 64'(in_ready), 64'd1);
    checkOutput("stall out_valid after release", 64'(out_valid), 64'd0);

    $display("[TB] in_valid during RUN is ignored");
    a        = 32'h0F0F_0F0F;
    b        = 32'h0101_0101;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a   = 32'hAAAA_AAAA;
    b   = 32'hAAAA_AAAA;
    cin = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("ignore s", 64'(s), 64'h1010_1010);
    checkOutput("ignore cout", 64'(cout), 64'd0);
    checkOutput("ignore out_valid", 64'(out_valid), 64'd1);
    releaseResult();

    $display("[TB] reset during RUN");
    a        = 32'hFFFF_FFFF;
    b        = 32'hFFFF_FFFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrun reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrun reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrun reset s", 64'(s), 64'd0);
    checkOutput("midrun reset busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checkOutput("midrun reset no result", 64'(seen), 64'd0);

    $display("[TB] randomized throttled traffic");
    got      = 0;
    last_acc = -100;
    fork
      begin : driver
        for (int i = 0; i < NRAND; i++) begin
          int wait_cnt;
          int acc_cyc;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            @(negedge clk);
          end
          a        = $urandom;
          b        = $urandom;
          cin      = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          wait_cnt = 0;
          while (!in_ready && wait_cnt < 200) begin
            @(posedge clk);
            @(negedge clk);
            wait_cnt++;
          end
          if (!in_ready) begin
            checkOutput("random accept timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            break;
          end
          acc_cyc = cyc + 1;
          expq.push_back({1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin});
          if (i > 0) checkOutput("random issue interval ok", 64'(acc_cyc - last_acc >= WORDS + 2), 64'd1);
          last_acc = acc_cyc;
          @(posedge clk);
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin : monitor
        int guard = 0;
        while (got < NRAND && guard < 60000) begin
          @(negedge clk);
          guard++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
              checkOutput("random spurious result", 64'd1, 64'd0);
            end else begin
              checkOutput("random sum", 64'({cout, s}), 64'(expq.pop_front()));
            end
            got++;
          end
        end
        out_ready = 1'b0;
        if (got < NRAND) checkOutput("random result count", 64'(got), 64'(NRAND));
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
